pimac_pipe: RTL and testbench
=============================

PIMAC_PIPE -- requirements
Module: pimac_pipe

Interface
REQ-001 Parameter A_W, default 4: operand a width.
REQ-002 Parameter B_W, default 4: operand b width.
REQ-003 Parameter C_W, default 4: addend c width.
REQ-004 Parameter ACC_W, default 8: result/accumulator width; SHALL be >= A_W+B_W.
REQ-005 Parameter SIGNED, default 0: 0 = unsigned, 1 = two's-complement for a, b, c, acc and result.
REQ-006 Port clk  input  1  sole clock; all state on rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port in_valid  input  1  input beat offered.
REQ-009 Port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-010 Port a  input  A_W  multiplicand.
REQ-011 Port b  input  B_W  multiplier.
REQ-012 Port c  input  C_W  addend.
REQ-013 Port mode  input  2  operation: 00 MAC, 01 ACC, 10 LOAD, 11 treated as MAC.
REQ-014 Port sat_en  input  1  1 = saturate, 0 = wrap; sampled with the beat.
REQ-015 Port out_valid  output  1  result beat present.
REQ-016 Port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-017 Port result  output  ACC_W  result value.
REQ-018 Port overflow  output  1  beat's exact value was outside ACC_W range.

Function
REQ-019 Stage 1 SHALL register p = a*b at full A_W+B_W precision, plus c, mode and sat_en, with a stage-valid bit.
REQ-020 Stage 2 SHALL compute the exact sum at ACC_W+2 bits (sign/zero-extended per SIGNED) and register result, overflow and out_valid.
REQ-021 MAC: sum = p + c; accumulator unchanged.
REQ-022 ACC: sum = acc + p; acc <= the final (saturated or wrapped) result.
REQ-023 LOAD: sum = p + c; acc <= the final result.
REQ-024 overflow SHALL be 1 iff the exact sum lies outside the ACC_W range (unsigned 0..2^ACC_W-1 or signed -2^(ACC_W-1)..2^(ACC_W-1)-1), independent of sat_en.
REQ-025 With sat_en=1, out-of-range sums SHALL clamp to the nearest range limit; with sat_en=0, result SHALL be the sum modulo 2^ACC_W.
REQ-026 Latency SHALL be 2 cycles from input acceptance to out_valid when not stalled; throughput 1 beat/cycle with out_ready held high.
REQ-027 stall = out_valid && !out_ready; in_ready SHALL equal !stall combinationally; on stall, all pipeline registers and acc SHALL hold.
REQ-028 result and overflow SHALL be stable while out_valid && !out_ready.
REQ-029 Bubbles SHALL propagate and clear out_valid; they SHALL NOT modify acc.
REQ-030 Back-to-back ACC beats SHALL each see the acc written by the preceding beat, with no extra latency.
REQ-031 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-032 While rst_n=0: stage valids=0, out_valid=0, result=0, overflow=0, acc=0.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Reset assertion mid-operation SHALL discard in-flight beats immediately; the first beat accepted after release SHALL see acc=0.

Structure
REQ-035 Mode encodings (MAC, ACC, LOAD) SHALL be constants in shared package pimac_pkg.
REQ-036 Range-check/saturate/wrap logic SHALL be one sub-module, pimac_sat, parameterised by in width, ACC_W and SIGNED.
REQ-037 Implementation SHALL contain no latches and no clock gating.

Verification (defaults unless stated)
REQ-038 MAC a=15,b=15,c=15, out_ready=1 -> 2 cycles later result=240, overflow=0; acc unchanged at 0.
REQ-039 LOAD a=15,b=15,c=15 then ACC a=15,b=15,sat_en=1 -> results 240/ov0, then 255/ov1; acc=255.
REQ-040 Same as REQ-039 with sat_en=0 -> second result 209, overflow=1; acc=209.
REQ-041 SIGNED=1: MAC a=-8,b=-8,c=7 -> 71 ov0; MAC a=-8,b=7,c=-8 -> -64 ov0.
REQ-042 Stream 4 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready low while stalled, result held stable, all 4 results in order, no loss or duplication.
REQ-043 rst_n low for 1 cycle with 2 ACC beats in flight -> out_valid=0 immediately; next ACC a=1,b=1 -> result=1.

Source files
------------

// File: rtl/pimac_pkg.sv
// Shared constants for the pipelined multiply-accumulate block.
// Mode encodings are shared by the datapath and anything that builds beats for it.
package pimac_pkg;

  localparam logic [1:0] MODE_MAC  = 2'b00;
  localparam logic [1:0] MODE_ACC  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;

  localparam int STAGES = 2;

  // 2'b11 falls through to MAC behaviour and leaves the accumulator alone
  function automatic logic writes_acc(input logic [1:0] mode);
    return (mode == MODE_ACC) || (mode == MODE_LOAD);
  endfunction

endpackage

// File: rtl/pimac_pipe_if.sv
// Beat-in / result-out handshake bundle for pimac_pipe.
// master = producer/consumer around the block, slave = the block itself.
interface pimac_pipe_if #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int C_W   = 4,
  parameter int ACC_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [C_W-1:0]   c;
  logic [1:0]       mode;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport master (
    output in_valid, a, b, c, mode, sat_en, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, c, mode, sat_en, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/pimac_sat.sv
// Range check of an exact sum against ACC_W, then clamp or wrap.
// The overflow flag reflects the exact sum regardless of sat_en.
module pimac_sat
  import pimac_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic [IN_W-1:0]  sum,
  input  logic             sat_en,
  output logic [ACC_W-1:0] res,
  output logic             ov
);

  logic [ACC_W-1:0] lim;

  generate
    if (SIGNED != 0) begin : g_signed
      // in range iff every bit from the ACC_W sign bit upward agrees
      assign ov  = !((&sum[IN_W-1:ACC_W-1]) || !(|sum[IN_W-1:ACC_W-1]));
      assign lim = sum[IN_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_unsigned
      // unsigned operands only add, so the low limit is never crossed
      assign ov  = |sum[IN_W-1:ACC_W];
      assign lim = '1;
    end
  endgenerate

  assign res = (ov && sat_en) ? lim : sum[ACC_W-1:0];

endmodule

// File: rtl/pimac_pipe.sv
// Two-stage multiply / add / accumulate with valid-ready flow control.
// Stage 1 registers the full-width product; stage 2 adds, range-checks and updates acc.
module pimac_pipe
  import pimac_pkg::*;
#(
  parameter int A_W    = 4,
  parameter int B_W    = 4,
  parameter int C_W    = 4,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input logic         clk,
  input logic         rst_n,
  pimac_pipe_if.slave bus
);

  localparam int P_W = A_W + B_W;
  localparam int S_W = ACC_W + 2;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic [C_W-1:0] c;
    logic [1:0]     mode;
    logic           sat_en;
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_q;
  logic             ov_q;

  logic             stall;
  logic             accept;
  logic             sx_a, sx_b, sx_p, sx_c, sx_acc;
  logic [P_W-1:0]   a_x, b_x, prod;
  logic [S_W-1:0]   p_x, c_x, acc_x, sum;
  logic [ACC_W-1:0] sat_res;
  logic             sat_ov;

  assign stall        = vld_pipe[2] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;

  assign sx_a   = (SIGNED != 0) && bus.a[A_W-1];
  assign sx_b   = (SIGNED != 0) && bus.b[B_W-1];
  assign sx_p   = (SIGNED != 0) && s1.p[P_W-1];
  assign sx_c   = (SIGNED != 0) && s1.c[C_W-1];
  assign sx_acc = (SIGNED != 0) && acc[ACC_W-1];

  // extend before multiplying so the low P_W bits are the exact product either way
  assign a_x  = {{B_W{sx_a}}, bus.a};
  assign b_x  = {{A_W{sx_b}}, bus.b};
  assign prod = a_x * b_x;

  assign p_x   = {{(S_W-P_W){sx_p}}, s1.p};
  assign c_x   = {{(S_W-C_W){sx_c}}, s1.c};
  assign acc_x = {{2{sx_acc}}, acc};
  assign sum   = (s1.mode == MODE_ACC) ? (acc_x + p_x) : (p_x + c_x);

  pimac_sat #(
    .IN_W  (S_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_sat (
    .sum   (sum),
    .sat_en(s1.sat_en),
    .res   (sat_res),
    .ov    (sat_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      acc      <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[1], accept};
      if (accept)
        s1 <= '{p: prod, c: bus.c, mode: bus.mode, sat_en: bus.sat_en};
      // acc is written in the same stage that reads it, so back-to-back ACC needs no bypass
      if (vld_pipe[1]) begin
        res_q <= sat_res;
        ov_q  <= sat_ov;
        if (writes_acc(s1.mode))
          acc <= sat_res;
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.result    = res_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_pimac_pipe.sv
// Bench for pimac_pipe: unsigned and signed instances against an integer reference model.
module tb_pimac_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pimac_pipe_if #(.A_W(4), .B_W(4), .C_W(4), .ACC_W(8)) bu ();
  pimac_pipe_if #(.A_W(4), .B_W(4), .C_W(4), .ACC_W(8)) bs ();

  pimac_pipe #(.A_W(4), .B_W(4), .C_W(4), .ACC_W(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bu.slave));
  pimac_pipe #(.A_W(4), .B_W(4), .C_W(4), .ACC_W(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));

  int checks = 0;
  int errors = 0;
  int acc_u = 0;
  int acc_s = 0;
  logic [8:0] exp_u[$], exp_s[$], obs_u[$], obs_s[$];

  // record every completed output handshake as {overflow, result}
  always @(negedge clk) begin
    if (rst_n) begin
      if (bu.out_valid && bu.out_ready) obs_u.push_back({bu.overflow, bu.result});
      if (bs.out_valid && bs.out_ready) obs_s.push_back({bs.overflow, bs.result});
    end
  end

  function automatic int sx(input int v, input int w, input bit sgn);
    return (sgn && v[w-1]) ? v - (1 << w) : v;
  endfunction

  // exact integer arithmetic, then range check against the 8-bit result space
  function automatic void model(input bit sgn, input int a, input int b, input int c,
                                input int mode, input bit sat, inout int acc,
                                output logic [7:0] r, output logic ov);
    int p, sum, lo, hi, v;
    p   = sx(a, 4, sgn) * sx(b, 4, sgn);
    sum = (mode == 1) ? acc + p : p + sx(c, 4, sgn);
    lo  = sgn ? -128 : 0;
    hi  = sgn ? 127 : 255;
    ov  = (sum < lo) || (sum > hi);
    v   = (ov && sat) ? ((sum < lo) ? lo : hi) : sum;
    r   = v[7:0];
    if (mode == 1 || mode == 2) acc = sx(int'(r), 8, sgn);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    exp_u.delete(); exp_s.delete(); obs_u.delete(); obs_s.delete();
  endtask

  // offer one beat (caller is just past a rising edge); returns just past its acceptance edge
  task automatic send(input bit sgn, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [1:0] mode, input bit sat);
    logic [7:0] r;
    logic ov;
    int n = 0;
    bit done = 0;
    if (sgn) begin bs.in_valid = 1; bs.a = a; bs.b = b; bs.c = c; bs.mode = mode; bs.sat_en = sat; end
    else     begin bu.in_valid = 1; bu.a = a; bu.b = b; bu.c = c; bu.mode = mode; bu.sat_en = sat; end
    while (!done) begin
      @(negedge clk);
      if (sgn ? bs.in_ready : bu.in_ready) begin
        if (sgn) begin model(1, int'(a), int'(b), int'(c), int'(mode), sat, acc_s, r, ov); exp_s.push_back({ov, r}); end
        else     begin model(0, int'(a), int'(b), int'(c), int'(mode), sat, acc_u, r, ov); exp_u.push_back({ov, r}); end
        done = 1;
      end else if (++n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (sgn) bs.in_valid = 0; else bu.in_valid = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bu.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_u: got %b want 0", bu.out_valid); end
    checks++; if (bu.result !== 8'h00) begin errors++; $display("FAIL rst_result_u: got %h want 00", bu.result); end
    checks++; if (bu.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow_u: got %b want 0", bu.overflow); end
    checks++; if (bu.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_u: got %b want 1", bu.in_ready); end
    checks++; if (bs.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_s: got %b want 0", bs.out_valid); end
    checks++; if (bs.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_s: got %b want 1", bs.in_ready); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (bu.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", bu.in_ready); end
  endtask

  task automatic test_unsigned_directed();
    logic [8:0] want[10] = '{9'h0F0, 9'h000, 9'h0F0, 9'h1FF, 9'h0FF,
                             9'h0F0, 9'h1D1, 9'h0D1, 9'h007, 9'h0D1};
    clear_q();
    bu.out_ready = 1;
    send(0, 15, 15, 15, 2'b00, 0);
    checks++; if (bu.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid %b one cycle after accept, want 0", bu.out_valid); end
    @(posedge clk); #1;
    checks++; if (bu.out_valid !== 1'b1 || bu.result !== 8'd240 || bu.overflow !== 1'b0)
      begin errors++; $display("FAIL latency_2: valid %b result %0d ov %b, want 1/240/0", bu.out_valid, bu.result, bu.overflow); end
    send(0, 0, 0, 0, 2'b01, 0);     // acc probe: still 0 after MAC
    send(0, 15, 15, 15, 2'b10, 0);  // LOAD 240
    send(0, 15, 15, 0, 2'b01, 1);   // ACC saturating
    send(0, 0, 0, 0, 2'b01, 0);     // probe 255
    send(0, 15, 15, 15, 2'b10, 0);
    send(0, 15, 15, 0, 2'b01, 0);   // ACC wrapping
    send(0, 0, 0, 0, 2'b01, 0);     // probe 209
    send(0, 2, 3, 1, 2'b11, 0);     // mode 11 behaves as MAC
    send(0, 0, 0, 0, 2'b01, 0);     // acc untouched by mode 11
    idle(4);
    checks++; if (obs_u.size() != 10) begin errors++; $display("FAIL dir_u_count: got %0d want 10", obs_u.size()); end
    for (int i = 0; i < 10 && i < obs_u.size(); i++) begin
      checks++; if (obs_u[i] !== want[i]) begin errors++; $display("FAIL dir_u_beat%0d: got ov/res %h want %h", i, obs_u[i], want[i]); end
    end
  endtask

  task automatic test_signed_directed();
    logic [8:0] want[9] = '{9'h047, 9'h0C0, 9'h047, 9'h17F, 9'h047,
                            9'h0C0, 9'h088, 9'h180, 9'h148};
    clear_q();
    bs.out_ready = 1;
    send(1, 4'h8, 4'h8, 4'h7, 2'b00, 0);  // -8*-8+7 = 71
    send(1, 4'h8, 4'h7, 4'h8, 2'b00, 0);  // -8*7-8 = -64
    send(1, 4'h8, 4'h8, 4'h7, 2'b10, 0);  // acc = 71
    send(1, 4'h8, 4'h8, 4'h0, 2'b01, 1);  // 135 -> 127
    send(1, 4'h8, 4'h7, 4'h0, 2'b01, 1);  // 71
    send(1, 4'h8, 4'h7, 4'h8, 2'b10, 0);  // acc = -64
    send(1, 4'h8, 4'h7, 4'h0, 2'b01, 1);  // -120
    send(1, 4'h8, 4'h7, 4'h0, 2'b01, 1);  // -176 -> -128
    send(1, 4'h8, 4'h7, 4'h0, 2'b01, 0);  // -184 wraps to 72
    idle(4);
    checks++; if (obs_s.size() != 9) begin errors++; $display("FAIL dir_s_count: got %0d want 9", obs_s.size()); end
    for (int i = 0; i < 9 && i < obs_s.size(); i++) begin
      checks++; if (obs_s[i] !== want[i]) begin errors++; $display("FAIL dir_s_beat%0d: got ov/res %h want %h", i, obs_s[i], want[i]); end
    end
  endtask

  task automatic test_stall();
    clear_q();
    bu.out_ready = 1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(0, 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom_range(0, 2)), 1'($urandom));
      end
      begin
        logic [8:0] held;
        repeat (2) @(posedge clk);
        #1 bu.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++; if (bu.in_ready !== 1'b0 || bu.out_valid !== 1'b1)
            begin errors++; $display("FAIL stall_ready: in_ready %b out_valid %b, want 0/1", bu.in_ready, bu.out_valid); end
          if (k == 0) held = {bu.overflow, bu.result};
          else begin
            checks++; if ({bu.overflow, bu.result} !== held)
              begin errors++; $display("FAIL stall_hold: got %h want %h", {bu.overflow, bu.result}, held); end
          end
        end
        @(posedge clk); #1 bu.out_ready = 1;
      end
    join
    idle(6);
    checks++; if (obs_u.size() != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", obs_u.size()); end
    for (int i = 0; i < 4 && i < obs_u.size(); i++) begin
      checks++; if (obs_u[i] !== exp_u[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_u[i], exp_u[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bu.out_ready = 1;
    send(0, 3, 3, 0, 2'b01, 0);
    send(0, 5, 5, 0, 2'b01, 0);
    rst_n = 0;
    #1;
    checks++; if (bu.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bu.out_valid); end
    @(negedge clk);
    checks++; if (bu.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bu.in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; acc_u = 0; acc_s = 0;
    clear_q();
    @(posedge clk); #1;
    send(0, 1, 1, 0, 2'b01, 0);
    idle(4);
    checks++; if (obs_u.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", obs_u.size()); end
    else begin
      checks++; if (obs_u[0] !== 9'h001) begin errors++; $display("FAIL midrst_acc0: got %h want 001", obs_u[0]); end
    end
  endtask

  task automatic test_random(input bit sgn);
    bit stream_done = 0;
    logic [8:0] e[$], o[$];
    clear_q();
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(sgn, 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          if (sgn) bs.out_ready = ($urandom_range(0, 3) != 0);
          else     bu.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bu.out_ready = 1; bs.out_ready = 1;
    idle(6);
    e = sgn ? exp_s : exp_u;
    o = sgn ? obs_s : obs_u;
    checks++; if (o.size() != e.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", sgn, o.size(), e.size()); end
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      checks++; if (o[i] !== e[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", sgn, i, o[i], e[i]); end
    end
  endtask

  initial begin
    bu.in_valid = 0; bu.a = 0; bu.b = 0; bu.c = 0; bu.mode = 0; bu.sat_en = 0; bu.out_ready = 1;
    bs.in_valid = 0; bs.a = 0; bs.b = 0; bs.c = 0; bs.mode = 0; bs.sat_en = 0; bs.out_ready = 1;
    test_reset();
    test_unsigned_directed();
    test_signed_directed();
    test_stall();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
